// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode constants used by fetch and the control unit,
// plus the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_J      = 7'b1101111;
  localparam logic [6:0] OP_J_I    = 7'b1100111;
  localparam logic [6:0] OP_U      = 7'b0110111;
  localparam logic [6:0] OP_U_PC   = 7'b0010111;
  localparam logic [6:0] OP_E      = 7'b1110011;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential step or branch target, with a
// word-alignment check on the chosen address.
module pc_next_logic
  import riscv_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] pc,
  input  logic                branch_taken,
  input  logic [WORDSIZE-1:0] branch_target,
  output logic [WORDSIZE-1:0] next_pc,
  output logic                misaligned
);

  localparam logic [WORDSIZE-1:0] STEP = WORDSIZE'(INSTR_BYTES);

  // The add wraps naturally modulo 2^WORDSIZE.
  assign next_pc    = branch_taken ? branch_target : (pc + STEP);
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches one instruction over req/ready and
// holds it for the control unit until it retires via advance.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned          WORDSIZE         = 64,
  parameter int unsigned          INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0]  RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic                        imem_ready,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  input  logic                        advance,
  input  logic                        branch_taken,
  input  logic [WORDSIZE-1:0]         branch_target,
  output logic [INSTRUCTION_SIZE-1:0] instr,
  output logic [6:0]                  opcode,
  output logic [WORDSIZE-1:0]         pc,
  output logic                        instr_valid,
  output logic                        fetch_fault,
  output logic [WORDSIZE-1:0]         retired_count
);

  localparam logic [WORDSIZE-1:0] ONE = WORDSIZE'(1);

  fetch_state_e                state_q, state_d;
  logic                        armed_q, armed_d;
  logic [WORDSIZE-1:0]         pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
  logic [WORDSIZE-1:0]         retired_q, retired_d;
  logic                        fault_q, fault_d;

  logic [WORDSIZE-1:0]         next_pc;
  logic                        misaligned;

  pc_next_logic #(
    .WORDSIZE(WORDSIZE)
  ) u_pc_next (
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    case (state_q)
      // IDLE spends one full cycle after reset release before the first request.
      FS_IDLE: begin
        if (armed_q) begin
          state_d = FS_FETCH;
        end else begin
          armed_d = 1'b1;
        end
      end
      FS_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (advance) begin
          retired_d = retired_q + ONE;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = FS_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = FS_FETCH;
          end
        end
      end
      FS_FAULT: begin
        state_d = FS_FAULT;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FS_IDLE;
      armed_q   <= 1'b0;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  assign imem_req      = (state_q == FS_FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid   = (state_q == FS_HOLD);
  assign instr         = instr_q;
  assign opcode        = instr_q[6:0];
  assign pc            = pc_q;
  assign fetch_fault   = fault_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: default instance plus a
// second instance with RESET_PC at the top of the address space for wrap checks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        advance;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [63:0] pc;
  logic        instr_valid;
  logic        fetch_fault;
  logic [63:0] retired_count;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_ready;
  logic [31:0] w_rdata;
  logic        w_advance;
  logic        w_bt;
  logic [63:0] w_target;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [63:0] w_pc;
  logic        w_valid;
  logic        w_fault;
  logic [63:0] w_retired;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  always #5 clk = ~clk;

  instruction_fetch u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .advance      (advance),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr        (instr),
    .opcode       (opcode),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .fetch_fault  (fetch_fault),
    .retired_count(retired_count)
  );

  instruction_fetch #(
    .RESET_PC(WRAP_PC)
  ) u_dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ready   (w_ready),
    .imem_rdata   (w_rdata),
    .advance      (w_advance),
    .branch_taken (w_bt),
    .branch_target(w_target),
    .instr        (w_instr),
    .opcode       (w_opcode),
    .pc           (w_pc),
    .instr_valid  (w_valid),
    .fetch_fault  (w_fault),
    .retired_count(w_retired)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    advance = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    w_ready = 1'b1; w_rdata = 32'h0000_0013;
    w_advance = 1'b0; w_bt = 1'b0; w_target = 64'h0;

    tick(); tick();
    check_eq("rst_pc", pc, 64'h0);
    check_eq("rst_instr", {32'h0, instr}, 64'h0);
    check_eq("rst_retired", retired_count, 64'h0);
    check_eq("rst_req", {63'h0, imem_req}, 64'h0);
    check_eq("rst_valid", {63'h0, instr_valid}, 64'h0);
    check_eq("rst_fault", {63'h0, fetch_fault}, 64'h0);
    check_eq("rst_wrap_pc", w_pc, WRAP_PC);

    // Zero-wait fetch of addi; ready high early is ignored while idle.
    rst_n = 1'b1;
    imem_ready = 1'b1; imem_rdata = 32'h00A0_0093;
    tick();
    check_eq("edgeR_req", {63'h0, imem_req}, 64'h0);
    tick();
    check_eq("edgeR1_req", {63'h0, imem_req}, 64'h1);
    check_eq("edgeR1_addr", imem_addr, 64'h0);
    tick();
    check_eq("f0_valid", {63'h0, instr_valid}, 64'h1);
    check_eq("f0_req", {63'h0, imem_req}, 64'h0);
    check_eq("f0_instr", {32'h0, instr}, 64'h00A0_0093);
    check_eq("f0_opcode", {57'h0, opcode}, 64'h13);
    check_eq("f0_pc", pc, 64'h0);
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check_eq("hold_valid", {63'h0, instr_valid}, 64'h1);

    // Advance 1, then three wait states with a stray advance during FETCH.
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check_eq("adv1_valid", {63'h0, instr_valid}, 64'h0);
    check_eq("adv1_req", {63'h0, imem_req}, 64'h1);
    check_eq("adv1_addr", imem_addr, 64'h4);
    check_eq("adv1_retired", retired_count, 64'h1);
    for (int i = 0; i < 3; i++) begin
      advance = (i == 1);
      imem_rdata = 32'hBAD0_0000 + i;
      tick();
      check_eq("wait_req", {63'h0, imem_req}, 64'h1);
      check_eq("wait_addr", imem_addr, 64'h4);
      check_eq("wait_valid", {63'h0, instr_valid}, 64'h0);
      check_eq("wait_retired", retired_count, 64'h1);
      check_eq("wait_instr", {32'h0, instr}, 64'h00A0_0093);
    end
    advance = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h0040_0113;
    tick();
    imem_ready = 1'b0;
    check_eq("f1_valid", {63'h0, instr_valid}, 64'h1);
    check_eq("f1_instr", {32'h0, instr}, 64'h0040_0113);
    check_eq("f1_pc", pc, 64'h4);

    // Advances 2 and 3 with zero-wait fetches.
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check_eq("adv2_pc", pc, 64'h8);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
    tick();
    imem_ready = 1'b0;
    check_eq("f2_opcode", {57'h0, opcode}, 64'h33);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check_eq("adv3_pc", pc, 64'hC);
    check_eq("adv3_retired", retired_count, 64'h3);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0063;
    tick();
    imem_ready = 1'b0;
    check_eq("f3_valid", {63'h0, instr_valid}, 64'h1);

    // Taken branch to 0x100.
    advance = 1'b1; branch_taken = 1'b1; branch_target = 64'h100;
    tick();
    advance = 1'b0; branch_taken = 1'b0;
    check_eq("br_addr", imem_addr, 64'h100);
    check_eq("br_req", {63'h0, imem_req}, 64'h1);
    check_eq("br_retired", retired_count, 64'h4);
    imem_ready = 1'b1; imem_rdata = 32'h0000_006F;
    tick();
    imem_ready = 1'b0;
    check_eq("br_valid", {63'h0, instr_valid}, 64'h1);

    // Misaligned branch target faults and sticks.
    advance = 1'b1; branch_taken = 1'b1; branch_target = 64'h102;
    tick();
    check_eq("flt_fault", {63'h0, fetch_fault}, 64'h1);
    check_eq("flt_req", {63'h0, imem_req}, 64'h0);
    check_eq("flt_valid", {63'h0, instr_valid}, 64'h0);
    check_eq("flt_pc", pc, 64'h100);
    check_eq("flt_retired", retired_count, 64'h5);
    imem_ready = 1'b1; branch_target = 64'h200;
    tick(); tick(); tick();
    advance = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    check_eq("flt_stuck_fault", {63'h0, fetch_fault}, 64'h1);
    check_eq("flt_stuck_req", {63'h0, imem_req}, 64'h0);
    check_eq("flt_stuck_pc", pc, 64'h100);
    check_eq("flt_stuck_retired", retired_count, 64'h5);

    // Reset clears the fault.
    rst_n = 1'b0;
    tick();
    check_eq("rst2_fault", {63'h0, fetch_fault}, 64'h0);
    check_eq("rst2_pc", pc, 64'h0);
    check_eq("rst2_retired", retired_count, 64'h0);

    // Reset on the same edge as an accepted fetch.
    rst_n = 1'b1;
    tick(); tick();
    check_eq("mid_req", {63'h0, imem_req}, 64'h1);
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678; rst_n = 1'b0;
    tick();
    check_eq("mid_instr", {32'h0, instr}, 64'h0);
    check_eq("mid_valid", {63'h0, instr_valid}, 64'h0);
    check_eq("mid_pc", pc, 64'h0);
    check_eq("mid_req0", {63'h0, imem_req}, 64'h0);
    rst_n = 1'b1;
    tick();
    check_eq("mid_R_req", {63'h0, imem_req}, 64'h0);
    tick();
    check_eq("mid_R1_req", {63'h0, imem_req}, 64'h1);
    tick();
    check_eq("mid_f_instr", {32'h0, instr}, 64'h1234_5678);

    // Wrap instance: reached HOLD at top of memory; advance wraps to 0.
    check_eq("wrap_valid", {63'h0, w_valid}, 64'h1);
    check_eq("wrap_pc0", w_pc, WRAP_PC);
    w_ready = 1'b0;
    w_advance = 1'b1;
    tick();
    w_advance = 1'b0;
    check_eq("wrap_pc", w_pc, 64'h0);
    check_eq("wrap_addr", w_addr, 64'h0);
    check_eq("wrap_req", {63'h0, w_req}, 64'h1);
    check_eq("wrap_fault", {63'h0, w_fault}, 64'h0);
    check_eq("wrap_retired", w_retired, 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
